// File: rtl/ghost_mode_ctrl_pkg.sv
// Shared ghost types: mode encoding used by movement,
// sprite colour and the mode sequencer, plus a width helper.
package ghost_pkg;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_FRIGHT  = 2'd2
  } mode_t;

  localparam int IDX_W = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ghost_mode_ctrl_if.sv
// Ghost sequencer bus: tick/pellet/enable in, mode state out.
// master = game core side, slave = ghost_mode_ctrl.
interface ghost_mode_ctrl_if #(
  parameter int FRIGHT_TICKS = 6
);
  import ghost_pkg::*;

  localparam int FW = $clog2(FRIGHT_TICKS + 1);

  logic             tick;
  logic             game_en;
  logic             pellet_eaten;
  mode_t            mode;
  logic             flashing;
  logic             reverse;
  logic [IDX_W-1:0] phase_idx;
  logic [FW-1:0]    fright_left;

  modport master (
    output tick, game_en, pellet_eaten,
    input  mode, flashing, reverse,
    input  phase_idx, fright_left
  );

  modport slave (
    input  tick, game_en, pellet_eaten,
    output mode, flashing, reverse,
    output phase_idx, fright_left
  );

endinterface

// File: rtl/ghost_mode_ctrl_countdown.sv
// tick_countdown: loadable down-counter that stops at 1.
// Ports: load_i/load_val_i load, dec_i decrement, value_o, at_one_o.
module tick_countdown #(
  parameter int MAX     = 7,
  parameter int RST_VAL = MAX,
  localparam int W      = $clog2(MAX + 1)
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         at_one_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i)
      value_d = load_val_i;
    else if (dec_i && value_q > W'(1))
      value_d = value_q - W'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) value_q <= W'(RST_VAL);
    else       value_q <= value_d;
  end

  assign value_o  = value_q;
  assign at_one_o = (value_q == W'(1));

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Ghost SCATTER/CHASE/FRIGHT sequencer driven by timer ticks.
// Ports: CLOCK_50, reset (sync, high), bus (slave modport).
module ghost_mode_ctrl
  import ghost_pkg::*;
#(
  parameter int SCATTER_TICKS = 7,
  parameter int CHASE_TICKS   = 20,
  parameter int FRIGHT_TICKS  = 6,
  parameter int FLASH_TICKS   = 2,
  parameter int NUM_PAIRS     = 4
) (
  input logic         CLOCK_50,
  input logic         reset,
  ghost_mode_ctrl_if.slave bus
);

  localparam int PMAX = max_int(SCATTER_TICKS, CHASE_TICKS);
  localparam int PW   = $clog2(PMAX + 1);
  localparam int FW   = $clog2(FRIGHT_TICKS + 1);

  mode_t            mode_q, mode_d;
  mode_t            base_q, base_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rev_q, rev_want;
  logic             flash_q, flash_d;

  logic          ph_load, ph_dec, ph_one;
  logic [PW-1:0] ph_val, ph_value;
  logic          fr_load, fr_dec, fr_one;
  logic [FW-1:0] fr_val, fr_value, fr_nxt;

  logic et, ep, in_fr, perm;

  assign et    = bus.tick & bus.game_en;
  assign ep    = bus.pellet_eaten & bus.game_en;
  assign in_fr = (mode_q == MODE_FRIGHT);
  assign perm  = (int'(idx_q) >= NUM_PAIRS);

  always_comb begin
    ph_load  = 1'b0;
    ph_val   = PW'(SCATTER_TICKS);
    ph_dec   = 1'b0;
    fr_load  = 1'b0;
    fr_val   = '0;
    fr_dec   = 1'b0;
    mode_d   = mode_q;
    base_d   = base_q;
    idx_d    = idx_q;
    rev_want = 1'b0;
    // Pellet wins over a same-cycle tick.
    if (ep) begin
      fr_load = 1'b1;
      fr_val  = FW'(FRIGHT_TICKS);
      mode_d  = MODE_FRIGHT;
      if (!in_fr) begin
        base_d   = mode_q;
        rev_want = 1'b1;
      end
    end else if (et && in_fr) begin
      if (fr_one) begin
        fr_load = 1'b1;
        mode_d  = base_q;
      end else begin
        fr_dec = (fr_value != '0);
      end
    end else if (et && !perm) begin
      if (!ph_one) begin
        ph_dec = (ph_value != '0);
      end else if (mode_q == MODE_SCATTER) begin
        mode_d   = MODE_CHASE;
        ph_load  = 1'b1;
        ph_val   = PW'(CHASE_TICKS);
        rev_want = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        // Last pair: chase holds forever, timer parked at 1.
        if (int'(idx_q) + 1 < NUM_PAIRS) begin
          mode_d   = MODE_SCATTER;
          ph_load  = 1'b1;
          rev_want = 1'b1;
        end
      end
    end
    fr_nxt = fr_load ? fr_val
           : fr_dec  ? fr_value - FW'(1)
           : fr_value;
    flash_d = (fr_nxt != '0) && (fr_nxt <= FW'(FLASH_TICKS));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q  <= MODE_SCATTER;
      base_q  <= MODE_SCATTER;
      idx_q   <= '0;
      rev_q   <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      // Back-to-back qualifying events still give one pulse.
      rev_q   <= rev_want & ~rev_q;
      flash_q <= flash_d;
    end
  end

  tick_countdown #(
    .MAX     (PMAX),
    .RST_VAL (SCATTER_TICKS)
  ) u_phase (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (ph_dec),
    .value_o    (ph_value),
    .at_one_o   (ph_one)
  );

  tick_countdown #(
    .MAX     (FRIGHT_TICKS),
    .RST_VAL (0)
  ) u_fright (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .load_i     (fr_load),
    .load_val_i (fr_val),
    .dec_i      (fr_dec),
    .value_o    (fr_value),
    .at_one_o   (fr_one)
  );

  assign bus.mode        = mode_q;
  assign bus.flashing    = flash_q;
  assign bus.reverse     = rev_q;
  assign bus.phase_idx   = idx_q;
  assign bus.fright_left = fr_value;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Scoreboard bench for ghost_mode_ctrl with small timers.
// Driver queues hand-computed results; monitor compares.
module tb_ghost_mode_ctrl;
  import ghost_pkg::*;

  localparam int S  = 3;
  localparam int C  = 5;
  localparam int F  = 4;
  localparam int FL = 2;
  localparam int NP = 2;

  typedef struct {
    mode_t m;
    bit    fl;
    bit    rv;
    int    idx;
    int    left;
    int    id;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  exp_t q[$];

  ghost_mode_ctrl_if #(.FRIGHT_TICKS(F)) bus ();

  ghost_mode_ctrl #(
    .SCATTER_TICKS (S),
    .CHASE_TICKS   (C),
    .FRIGHT_TICKS  (F),
    .FLASH_TICKS   (FL),
    .NUM_PAIRS     (NP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input int id,
                     input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d required=%0d",
               nm, id, act, req);
    end
  endtask

  always begin
    @(posedge CLOCK_50);
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("mode", e.id, int'(bus.mode), int'(e.m));
      chk("flashing", e.id, int'(bus.flashing), int'(e.fl));
      chk("reverse", e.id, int'(bus.reverse), int'(e.rv));
      chk("phase_idx", e.id, int'(bus.phase_idx), e.idx);
      chk("fright_left", e.id, int'(bus.fright_left), e.left);
    end
  end

  task automatic step(input bit r, input bit en,
                      input bit tk, input bit pl,
                      input mode_t m, input bit fl,
                      input bit rv, input int idx,
                      input int left);
    exp_t e;
    @(negedge CLOCK_50);
    reset            = r;
    bus.game_en      = en;
    bus.tick         = tk;
    bus.pellet_eaten = pl;
    step_no++;
    e.m = m; e.fl = fl; e.rv = rv;
    e.idx = idx; e.left = left; e.id = step_no;
    q.push_back(e);
  endtask

  initial begin
    bus.game_en      = 1'b0;
    bus.tick         = 1'b0;
    bus.pellet_eaten = 1'b0;

    // reset state and idle
    step(1, 1, 0, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 0, 0, MODE_SCATTER, 0, 0, 0, 0);
    // scatter lasts 3 ticks
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_CHASE,   0, 1, 0, 0);
    step(0, 1, 0, 0, MODE_CHASE,   0, 0, 0, 0);
    // chase lasts 5 ticks
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 0, MODE_CHASE, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 1, 1, 0);
    // second pair
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 1, 0);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 1, 0);
    step(0, 1, 1, 0, MODE_CHASE,   0, 1, 1, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 0, MODE_CHASE, 0, 0, 1, 0);
    // last chase expiry: permanent, no reverse
    step(0, 1, 1, 0, MODE_CHASE, 0, 0, 2, 0);
    for (int i = 0; i < 50; i++)
      step(0, 1, 1, 0, MODE_CHASE, 0, 0, 2, 0);

    // pellet at scatter timer=2
    step(1, 1, 0, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 0, 1, MODE_FRIGHT,  0, 1, 0, 4);
    step(0, 1, 1, 0, MODE_FRIGHT,  0, 0, 0, 3);
    step(0, 1, 1, 0, MODE_FRIGHT,  1, 0, 0, 2);
    step(0, 1, 1, 0, MODE_FRIGHT,  1, 0, 0, 1);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 0, 0);
    // two scatter ticks remained
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_CHASE,   0, 1, 0, 0);
    // pellet right after a reverse: no second pulse
    step(0, 1, 0, 1, MODE_FRIGHT,  0, 0, 0, 4);
    step(0, 1, 1, 0, MODE_FRIGHT,  0, 0, 0, 3);
    step(0, 1, 1, 0, MODE_FRIGHT,  1, 0, 0, 2);
    step(0, 1, 1, 0, MODE_FRIGHT,  1, 0, 0, 1);
    // re-pellet at left=1
    step(0, 1, 0, 1, MODE_FRIGHT,  0, 0, 0, 4);
    // pellet + tick: tick dropped
    step(0, 1, 1, 1, MODE_FRIGHT,  0, 0, 0, 4);
    step(0, 1, 1, 0, MODE_FRIGHT,  0, 0, 0, 3);
    // paused: everything frozen
    step(0, 0, 1, 0, MODE_FRIGHT,  0, 0, 0, 3);
    step(0, 0, 0, 1, MODE_FRIGHT,  0, 0, 0, 3);
    step(0, 0, 1, 1, MODE_FRIGHT,  0, 0, 0, 3);
    step(0, 1, 1, 0, MODE_FRIGHT,  1, 0, 0, 2);
    step(0, 1, 1, 0, MODE_FRIGHT,  1, 0, 0, 1);
    // resume chase with full 5-tick timer
    step(0, 1, 1, 0, MODE_CHASE,   0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 0, MODE_CHASE, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 1, 1, 0);
    // pause in scatter: no pellet reverse
    step(0, 0, 0, 1, MODE_SCATTER, 0, 0, 1, 0);
    step(0, 0, 1, 0, MODE_SCATTER, 0, 0, 1, 0);
    step(0, 1, 0, 1, MODE_FRIGHT,  0, 1, 1, 4);
    step(0, 1, 1, 0, MODE_FRIGHT,  0, 0, 1, 3);
    // reset during fright
    step(1, 1, 0, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_SCATTER, 0, 0, 0, 0);
    step(0, 1, 1, 0, MODE_CHASE,   0, 1, 0, 0);
    step(0, 1, 0, 0, MODE_CHASE,   0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge CLOCK_50);
    #2;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
